vga_text_writer: RTL

Wishbone-master text engine that turns a byte stream of character codes into writes into the text-mode video buffer of the `vga` adapter. It keeps the cursor position and drives the adapter's cursor inputs. It handles CR/LF/BS/FF and wraps at the end of a line. When a line feed arrives on the last line, it scrolls the user area (lines 1–24) up by reading and rewriting the buffer over the bus. Line 0, the service line, is never written, scrolled or cleared.

---
 rtl/vga_text_writer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_text_writer.sv
// Text engine for the vga adapter: turns character codes into Wishbone writes to the
// text buffer, tracks the cursor and scrolls/clears the user area (lines 1..ROWS-1).
module vga_text_writer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 25,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic [10:0] cursor,
  output logic        cursor_on,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PUT    = 3'd1;
  localparam logic [2:0] S_SCR_RD = 3'd2;
  localparam logic [2:0] S_SCR_WR = 3'd3;
  localparam logic [2:0] S_CLR    = 3'd4;

  localparam logic [9:0]  W_HALF      = 10'(COLS / 2);
  localparam logic [9:0]  W_LINE1     = 10'(COLS / 2);
  localparam logic [9:0]  W_SCR_FIRST = 10'(COLS);
  localparam logic [9:0]  W_LAST_LINE = 10'(((ROWS - 1) * COLS) / 2);
  localparam logic [9:0]  W_LAST      = 10'((ROWS * COLS) / 2 - 1);
  localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);
  localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
  localparam logic [10:0] A_COLS      = 11'(COLS);
  localparam logic [10:0] A_COLS_M1   = 11'(COLS - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [10:0] cadr_q, cadr_d;
  logic [9:0]  wadr_q, wadr_d;
  logic [15:0] rdat_q, rdat_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [9:0]  badr_q, badr_d;
  logic [15:0] dat_q, dat_d;
  logic [1:0]  sel_q, sel_d;
  logic        rdy_q;
  logic        busy_q;

  assign wb_adr_o  = {5'b0, badr_q, 1'b0};
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_cyc_o  = stb_q;
  assign wb_stb_o  = stb_q;
  assign cursor    = cadr_q;
  assign in_ready  = rdy_q;
  assign cursor_on = rdy_q;
  assign busy      = busy_q;

  // Next-state and next-register values; bus states issue a new access whenever stb is low
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cadr_d  = cadr_q;
    wadr_d  = wadr_q;
    rdat_d  = rdat_q;
    stb_d   = stb_q;
    we_d    = we_q;
    badr_d  = badr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20) begin
            state_d = S_PUT;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            badr_d  = cadr_q[10:1];
            dat_d   = {in_data, in_data};
            sel_d   = cadr_q[0] ? 2'b10 : 2'b01;
          end else begin
            case (in_data)
              8'h0D: begin
                col_d  = 7'd0;
                cadr_d = cadr_q - 11'(col_q);
              end
              8'h08: begin
                if (col_q != 7'd0) begin
                  col_d  = col_q - 7'd1;
                  cadr_d = cadr_q - 11'd1;
                end
              end
              8'h0A: begin
                if (row_q < ROW_LAST) begin
                  row_d  = row_q + 5'd1;
                  cadr_d = cadr_q + A_COLS;
                end else begin
                  state_d = S_SCR_RD;
                  wadr_d  = W_SCR_FIRST;
                end
              end
              8'h0C: begin
                state_d = S_CLR;
                wadr_d  = W_LINE1;
                row_d   = 5'd1;
                col_d   = 7'd0;
                cadr_d  = A_COLS;
              end
              default: ;
            endcase
          end
        end
      end

      S_PUT: begin
        if (wb_ack_i) begin
          stb_d = 1'b0;
          if (col_q < COL_LAST) begin
            col_d   = col_q + 7'd1;
            cadr_d  = cadr_q + 11'd1;
            state_d = S_IDLE;
          end else begin
            col_d = 7'd0;
            if (row_q < ROW_LAST) begin
              row_d   = row_q + 5'd1;
              cadr_d  = cadr_q + 11'd1;
              state_d = S_IDLE;
            end else begin
              // wrap on the last line: scroll immediately, the ack gap doubles as entry
              cadr_d  = cadr_q - A_COLS_M1;
              wadr_d  = W_SCR_FIRST;
              state_d = S_SCR_RD;
            end
          end
        end
      end

      S_SCR_RD: begin
        if (!stb_q) begin
          stb_d  = 1'b1;
          we_d   = 1'b0;
          badr_d = wadr_q;
          sel_d  = 2'b11;
        end else if (wb_ack_i) begin
          rdat_d  = wb_dat_i;
          stb_d   = 1'b0;
          state_d = S_SCR_WR;
        end
      end

      S_SCR_WR: begin
        if (!stb_q) begin
          stb_d  = 1'b1;
          we_d   = 1'b1;
          badr_d = wadr_q - W_HALF;
          dat_d  = rdat_q;
          sel_d  = 2'b11;
        end else if (wb_ack_i) begin
          stb_d = 1'b0;
          if (wadr_q == W_LAST) begin
            wadr_d  = W_LAST_LINE;
            state_d = S_CLR;
          end else begin
            wadr_d  = wadr_q + 10'd1;
            state_d = S_SCR_RD;
          end
        end
      end

      S_CLR: begin
        if (!stb_q) begin
          stb_d  = 1'b1;
          we_d   = 1'b1;
          badr_d = wadr_q;
          dat_d  = {FILL, FILL};
          sel_d  = 2'b11;
        end else if (wb_ack_i) begin
          stb_d = 1'b0;
          if (wadr_q == W_LAST) begin
            state_d = S_IDLE;
          end else begin
            wadr_d = wadr_q + 10'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      row_q   <= 5'd1;
      col_q   <= 7'd0;
      cadr_q  <= A_COLS;
      wadr_q  <= 10'd0;
      rdat_q  <= 16'd0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      badr_q  <= 10'd0;
      dat_q   <= 16'd0;
      sel_q   <= 2'b00;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cadr_q  <= cadr_d;
      wadr_q  <= wadr_d;
      rdat_q  <= rdat_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      badr_q  <= badr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdy_q   <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

endmodule
